// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped output port bank: CTRL bit layout
// and the word-index extraction used by the address decoder.
package io_pkg;

  localparam int CTRL_AUTO   = 0;
  localparam int CTRL_COMMIT = 1;

  // Byte-address bits that select a 32-bit word inside the 256-byte I/O window.
  localparam logic [31:0] IO_WORD_MASK = 32'h0000_00FC;

  typedef logic [5:0] io_word_t;

  function automatic io_word_t io_word(input logic [31:0] byte_addr);
    return io_word_t'((byte_addr & IO_WORD_MASK) >> 2);
  endfunction

endpackage

// File: rtl/io_port_reg.sv
// One double-buffered output port: byte-lane merged shadow register, live
// register loaded on commit or auto-write, and a one-cycle update pulse.
module io_port_reg #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [DW/8-1:0] be,
  input  logic [DW-1:0]   wdata,
  input  logic            auto_en,
  input  logic            commit,
  output logic [DW-1:0]   shadow,
  output logic [DW-1:0]   live,
  output logic            update
);

  logic [DW-1:0] shadow_q, shadow_d;
  logic [DW-1:0] live_q,   live_d;
  logic          update_q, update_d;
  logic [DW-1:0] lane_mask;
  logic [DW-1:0] merged;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < DW/8; k++) begin
      lane_mask[8*k +: 8] = {8{be[k]}};
    end
    merged   = (shadow_q & ~lane_mask) | (wdata & lane_mask);
    shadow_d = wr_en ? merged : shadow_q;

    live_d = live_q;
    // Commit samples the pre-write shadow; an auto-write on the same edge overrides it.
    if (commit)          live_d = shadow_q;
    if (wr_en && auto_en) live_d = merged;

    update_d = commit | (wr_en & auto_en);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      live_q   <= '0;
      update_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      live_q   <= live_d;
      update_q <= update_d;
    end
  end

  assign shadow = shadow_q;
  assign live   = live_q;
  assign update = update_q;

endmodule

// File: rtl/io_output_bank.sv
// Memory-mapped output port bank: NPORTS double-buffered DATA registers plus a
// CTRL word (AUTO mode, atomic COMMIT), with registered readback.
module io_output_bank
  import io_pkg::*;
#(
  parameter int          NPORTS    = 4,
  parameter int          DW        = 32,
  parameter logic [7:0]  BASE_ADDR = 8'h80
) (
  input  logic                 io_clk,
  input  logic                 reset,
  input  logic [31:0]          addr,
  input  logic [DW-1:0]        datain,
  input  logic [DW/8-1:0]      be,
  input  logic                 write_io_enable,
  input  logic                 read_io_enable,
  output logic [DW-1:0]        dataout,
  output logic [NPORTS*DW-1:0] out_ports,
  output logic [NPORTS-1:0]    out_update
);

  localparam io_word_t BASE_WORD = io_word({24'h0, BASE_ADDR});
  localparam io_word_t CTRL_WORD = io_word_t'(NPORTS);

  io_word_t        word_idx;
  logic            data_hit;
  logic            ctrl_hit;
  logic            ctrl_wr;
  logic [NPORTS-1:0] port_wr;
  logic [DW-1:0]   shadow [NPORTS];
  logic [DW-1:0]   rd_val;

  logic            auto_q,    auto_d;
  logic            pending_q, pending_d;
  logic [DW-1:0]   dataout_q, dataout_d;

  // Modular subtract: addresses below the base wrap to large indices and fall out as unmapped.
  always_comb begin
    word_idx = io_word(addr) - BASE_WORD;
    data_hit = (word_idx < CTRL_WORD);
    ctrl_hit = (word_idx == CTRL_WORD);
    ctrl_wr  = write_io_enable & ctrl_hit & be[0];
    for (int i = 0; i < NPORTS; i++) begin
      port_wr[i] = write_io_enable & data_hit & (word_idx == io_word_t'(i));
    end
  end

  always_comb begin
    auto_d    = ctrl_wr ? datain[CTRL_AUTO] : auto_q;
    // A pending commit always fires on the next edge, so pending only survives via a fresh request.
    pending_d = ctrl_wr & datain[CTRL_COMMIT];
  end

  always_comb begin
    rd_val = '0;
    if (ctrl_hit) begin
      rd_val[CTRL_AUTO]   = auto_q;
      rd_val[CTRL_COMMIT] = pending_q;
    end
    for (int i = 0; i < NPORTS; i++) begin
      if (data_hit && word_idx == io_word_t'(i)) rd_val = shadow[i];
    end
    dataout_d = read_io_enable ? rd_val : dataout_q;
  end

  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      auto_q    <= 1'b0;
      pending_q <= 1'b0;
      dataout_q <= '0;
    end else begin
      auto_q    <= auto_d;
      pending_q <= pending_d;
      dataout_q <= dataout_d;
    end
  end

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    io_port_reg #(.DW(DW)) u_port (
      .clk     (io_clk),
      .rst     (reset),
      .wr_en   (port_wr[i]),
      .be      (be),
      .wdata   (datain),
      .auto_en (auto_q),
      .commit  (pending_q),
      .shadow  (shadow[i]),
      .live    (out_ports[i*DW +: DW]),
      .update  (out_update[i])
    );
  end

  assign dataout = dataout_q;

endmodule

// File: tb/tb_io_output_bank.sv
// Directed-vector bench for io_output_bank (NPORTS=4, DW=32, BASE_ADDR=0x80).
module tb_io_output_bank;

  localparam int NPORTS = 4;
  localparam int DW     = 32;

  logic                 io_clk = 1'b0;
  logic                 reset;
  logic [31:0]          addr;
  logic [DW-1:0]        datain;
  logic [DW/8-1:0]      be;
  logic                 write_io_enable;
  logic                 read_io_enable;
  logic [DW-1:0]        dataout;
  logic [NPORTS*DW-1:0] out_ports;
  logic [NPORTS-1:0]    out_update;

  int n_checks = 0;
  int n_fail   = 0;

  io_output_bank #(.NPORTS(NPORTS), .DW(DW), .BASE_ADDR(8'h80)) dut (
    .io_clk          (io_clk),
    .reset           (reset),
    .addr            (addr),
    .datain          (datain),
    .be              (be),
    .write_io_enable (write_io_enable),
    .read_io_enable  (read_io_enable),
    .dataout         (dataout),
    .out_ports       (out_ports),
    .out_update      (out_update)
  );

  always #5 io_clk = ~io_clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; each task returns on the next falling edge,
  // so the state after the rising edge in between is visible to the caller.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a; datain = d; be = b; write_io_enable = 1'b1;
    @(negedge io_clk);
    write_io_enable = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; read_io_enable = 1'b1;
    @(negedge io_clk);
    read_io_enable = 1'b0;
    d = dataout;
  endtask

  task automatic idle();
    @(negedge io_clk);
  endtask

  logic [31:0] r;

  initial begin
    reset = 1'b1; addr = '0; datain = '0; be = '0;
    write_io_enable = 1'b0; read_io_enable = 1'b0;
    repeat (2) @(negedge io_clk);
    reset = 1'b0;
    idle();

    // 1. reset state
    check("rst_ports",  out_ports,  128'h0);
    check("rst_update", out_update, 4'b0000);
    check("rst_dout",   dataout,    32'h0);
    for (int i = 0; i < 4; i++) begin
      rd(32'h80 + 4*i, r);
      check($sformatf("rst_data%0d", i), r, 32'h0);
    end
    rd(32'h90, r);
    check("rst_ctrl", r, 32'h0);

    // 2. shadow write, then commit
    wr(32'h80, 32'h1234_5678, 4'b1111);
    check("t2_live_unchanged", out_ports, 128'h0);
    check("t2_no_pulse",       out_update, 4'b0000);
    rd(32'h80, r);
    check("t2_readback", r, 32'h1234_5678);
    idle();
    check("t2_dout_hold", dataout, 32'h1234_5678);
    wr(32'h90, 32'h2, 4'b1111);
    check("t2_pending_no_pulse_yet", out_update, 4'b0000);
    check("t2_live_not_yet",         out_ports, 128'h0);
    idle();
    check("t2_commit_pulse", out_update, 4'b1111);
    check("t2_commit_port0", out_ports, 128'h0000_0000_0000_0000_0000_0000_1234_5678);
    rd(32'h90, r);
    check("t2_ctrl_after", r, 32'h0);
    check("t2_pulse_gone", out_update, 4'b0000);

    // 3. byte-lane write
    wr(32'h80, 32'hAABB_CCDD, 4'b0101);
    rd(32'h80, r);
    check("t3_merge", r, 32'h12BB_56DD);
    check("t3_live_kept", out_ports, 128'h0000_0000_0000_0000_0000_0000_1234_5678);

    // 4. AUTO mode write goes live immediately
    wr(32'h90, 32'h1, 4'b0001);
    rd(32'h90, r);
    check("t4_ctrl_auto", r, 32'h1);
    wr(32'h88, 32'h0000_00FF, 4'b1111);
    check("t4_port2_live", out_ports, 128'h0000_0000_0000_00FF_0000_0000_1234_5678);
    check("t4_pulse", out_update, 4'b0100);
    idle();
    check("t4_pulse_gone", out_update, 4'b0000);

    // 5. commit with a concurrent DATA write (AUTO cleared by this CTRL write)
    wr(32'h90, 32'h2, 4'b0001);
    wr(32'h84, 32'h0000_0055, 4'b1111);
    check("t5_commit_pulse", out_update, 4'b1111);
    check("t5_ports", out_ports, 128'h0000_0000_0000_00FF_0000_0000_12BB_56DD);
    idle();
    check("t5_no_second_pulse", out_update, 4'b0000);
    rd(32'h84, r);
    check("t5_shadow1", r, 32'h0000_0055);
    check("t5_port1_old", out_ports, 128'h0000_0000_0000_00FF_0000_0000_12BB_56DD);

    // 6. unmapped access, CTRL write with be=0, then reset during pending
    wr(32'hA8, 32'hDEAD_BEEF, 4'b1111);
    check("t6_unmapped_ports", out_ports, 128'h0000_0000_0000_00FF_0000_0000_12BB_56DD);
    rd(32'hA8, r);
    check("t6_unmapped_read", r, 32'h0);
    rd(32'h80, r);
    check("t6_shadow0_kept", r, 32'h12BB_56DD);
    wr(32'h90, 32'h3, 4'b0000);
    idle();
    check("t6_be0_no_commit", out_update, 4'b0000);
    rd(32'h90, r);
    check("t6_be0_ctrl", r, 32'h0);
    wr(32'h90, 32'h2, 4'b0001);
    reset = 1'b1;
    #1;
    check("t6_rst_ports",  out_ports,  128'h0);
    check("t6_rst_update", out_update, 4'b0000);
    check("t6_rst_dout",   dataout,    32'h0);
    idle();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      idle();
      check($sformatf("t6_no_pulse_%0d", c), out_update, 4'b0000);
    end
    rd(32'h90, r);
    check("t6_ctrl_cleared", r, 32'h0);
    rd(32'h84, r);
    check("t6_shadow1_cleared", r, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
